// File: rtl/rx_pkt_buffer_pkg.sv
// -----------------------------------------------------------------------------
// packet_pkg
// Shared types and constants for the RX store-and-forward packet buffer.
//   RX_BUF_BEAT_W   : width of one stored beat {tuser, tlast, tkeep, tdata}
//   RX_BUF_*_LSB    : field offsets inside a stored beat
//   rx_buf_status_t : status word exported to the status register block
// -----------------------------------------------------------------------------
package packet_pkg;

    localparam int unsigned RX_BUF_DATA_W = 512;
    localparam int unsigned RX_BUF_KEEP_W = 64;
    localparam int unsigned RX_BUF_USER_W = 48;
    localparam int unsigned RX_BUF_BEAT_W = RX_BUF_DATA_W + RX_BUF_KEEP_W + 1 + RX_BUF_USER_W;

    localparam int unsigned RX_BUF_KEEP_LSB = RX_BUF_DATA_W;
    localparam int unsigned RX_BUF_LAST_BIT = RX_BUF_DATA_W + RX_BUF_KEEP_W;
    localparam int unsigned RX_BUF_USER_LSB = RX_BUF_LAST_BIT + 1;

    // Default buffer depth; the occupancy field is sized for it ([AW:0]).
    localparam int unsigned RX_BUF_DEPTH = 64;
    localparam int unsigned RX_BUF_OCC_W = $clog2(RX_BUF_DEPTH) + 1;

    typedef struct packed {
        logic [31:0]             pkt_committed;
        logic [31:0]             pkt_dropped;
        logic [31:0]             pkt_sent;
        logic [RX_BUF_OCC_W-1:0] occupancy;
    } rx_buf_status_t;

endpackage

// File: rtl/rx_buf_ram.sv
// -----------------------------------------------------------------------------
// rx_buf_ram
// Simple dual-port beat store, DEPTH x W, one write port and one read port
// with a registered read (maps onto block/ultra RAM). The read register only
// updates when rd_en_i is high, so a stalled read word stays put.
//   aclk      : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write word
//   rd_en_i   : read strobe (loads rd_data_o on the next edge)
//   rd_addr_i : read address
//   rd_data_o : registered read word
// -----------------------------------------------------------------------------
module rx_buf_ram
    import packet_pkg::*;
#(
    parameter int unsigned DEPTH = RX_BUF_DEPTH,
    parameter int unsigned W     = RX_BUF_BEAT_W,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge aclk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rx_pkt_buffer.sv
// -----------------------------------------------------------------------------
// rx_pkt_buffer
// Store-and-forward packet buffer between the RX filter and the QDMA C2H
// stream. Never back-pressures the filter; only complete packets become
// visible downstream; a packet that does not fit is discarded whole.
//   aclk, aresetn   : clock, synchronous active-low reset
//   s_axis_*        : 512-bit beats from the filter (tready is registered,
//                     low during reset, high from the first cycle after)
//   m_axis_*        : committed beats to QDMA, driven from an output register
//   buf_status      : packets committed / dropped / sent, and occupancy
// -----------------------------------------------------------------------------
module rx_pkt_buffer
    import packet_pkg::*;
#(
    parameter int unsigned DEPTH = RX_BUF_DEPTH
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_tvalid,
    input  logic [RX_BUF_DATA_W-1:0] s_axis_tdata,
    input  logic [RX_BUF_KEEP_W-1:0] s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic [RX_BUF_USER_W-1:0] s_axis_tuser,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [RX_BUF_DATA_W-1:0] m_axis_tdata,
    output logic [RX_BUF_KEEP_W-1:0] m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [RX_BUF_USER_W-1:0] m_axis_tuser,
    input  logic                     m_axis_tready,
    output rx_buf_status_t           buf_status
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [0:0] ST_ACCEPT = 1'b0;
    localparam logic [0:0] ST_DROP   = 1'b1;

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [0:0]  state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] wr_commit_q, wr_commit_d;
    // rd_ptr retires beats on the m_axis handshake; fetch_ptr runs ahead of
    // it feeding the RAM read register and the output register, so beats in
    // flight still hold their slot and still count in occupancy.
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] fetch_ptr_q, fetch_ptr_d;
    logic        s_ready_q;
    logic [31:0] cnt_commit_q, cnt_commit_d;
    logic [31:0] cnt_drop_q, cnt_drop_d;
    logic [31:0] cnt_sent_q, cnt_sent_d;
    logic        ram_vld_q, ram_vld_d;
    logic        out_vld_q, out_vld_d;
    logic [RX_BUF_BEAT_W-1:0] out_beat_q, out_beat_d;

    logic [AW:0] used;
    logic        full;
    logic        beat_acc;
    logic        ram_we;
    logic        ram_re;
    logic        out_load;
    logic        m_hs;
    logic [RX_BUF_BEAT_W-1:0] wr_beat;
    logic [RX_BUF_BEAT_W-1:0] ram_rdata;

    // used never exceeds DEPTH, so its MSB alone flags "no free slot".
    assign used     = wr_ptr_q - rd_ptr_q;
    assign full     = used[AW];
    assign beat_acc = s_axis_tvalid & s_ready_q;
    assign wr_beat  = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    // ---------------- write side ----------------
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_commit_d  = wr_commit_q;
        cnt_commit_d = cnt_commit_q;
        cnt_drop_d   = cnt_drop_q;
        ram_we       = 1'b0;
        if (beat_acc) begin
            case (state_q)
                ST_ACCEPT: begin
                    if (!full) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (s_axis_tlast) begin
                            wr_commit_d  = wr_ptr_q + PTR_ONE;
                            cnt_commit_d = cnt_commit_q + 32'd1;
                        end
                    end else begin
                        // Out of space: forget the partial packet and skip
                        // the rest of it.
                        wr_ptr_d   = wr_commit_q;
                        cnt_drop_d = cnt_drop_q + 32'd1;
                        if (!s_axis_tlast) begin
                            state_d = ST_DROP;
                        end
                    end
                end
                default: begin
                    if (s_axis_tlast) begin
                        state_d = ST_ACCEPT;
                    end
                end
            endcase
        end
    end

    // ---------------- read side ----------------
    assign m_hs     = out_vld_q & m_axis_tready;
    assign out_load = ram_vld_q & (~out_vld_q | m_axis_tready);
    assign ram_re   = (fetch_ptr_q != wr_commit_q) & (~ram_vld_q | out_load);

    always_comb begin
        fetch_ptr_d = ram_re ? fetch_ptr_q + PTR_ONE : fetch_ptr_q;
        rd_ptr_d    = m_hs ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ram_vld_d   = ram_re | (ram_vld_q & ~out_load);
        out_vld_d   = out_load | (out_vld_q & ~m_axis_tready);
        out_beat_d  = out_load ? ram_rdata : out_beat_q;
        cnt_sent_d  = (m_hs & out_beat_q[RX_BUF_LAST_BIT]) ? cnt_sent_q + 32'd1 : cnt_sent_q;
    end

    rx_buf_ram #(
        .DEPTH (DEPTH),
        .W     (RX_BUF_BEAT_W)
    ) u_ram (
        .aclk      (aclk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_beat),
        .rd_en_i   (ram_re),
        .rd_addr_i (fetch_ptr_q[AW-1:0]),
        .rd_data_o (ram_rdata)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_ACCEPT;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            s_ready_q    <= 1'b0;
            cnt_commit_q <= '0;
            cnt_drop_q   <= '0;
            cnt_sent_q   <= '0;
            ram_vld_q    <= 1'b0;
            out_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_commit_q  <= wr_commit_d;
            rd_ptr_q     <= rd_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            s_ready_q    <= 1'b1;
            cnt_commit_q <= cnt_commit_d;
            cnt_drop_q   <= cnt_drop_d;
            cnt_sent_q   <= cnt_sent_d;
            ram_vld_q    <= ram_vld_d;
            out_vld_q    <= out_vld_d;
        end
    end

    // Payload register carries no reset; out_vld_q qualifies it.
    always_ff @(posedge aclk) begin
        out_beat_q <= out_beat_d;
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_beat_q[RX_BUF_DATA_W-1:0];
    assign m_axis_tkeep  = out_beat_q[RX_BUF_KEEP_LSB +: RX_BUF_KEEP_W];
    assign m_axis_tlast  = out_beat_q[RX_BUF_LAST_BIT];
    assign m_axis_tuser  = out_beat_q[RX_BUF_USER_LSB +: RX_BUF_USER_W];

    assign buf_status.pkt_committed = cnt_commit_q;
    assign buf_status.pkt_dropped   = cnt_drop_q;
    assign buf_status.pkt_sent      = cnt_sent_q;
    assign buf_status.occupancy     = RX_BUF_OCC_W'(used);

endmodule

// File: tb/tb_rx_pkt_buffer.sv
module tb_rx_pkt_buffer;
    import packet_pkg::*;

    localparam int unsigned DEPTH = 64;

    logic                     aclk = 1'b0;
    logic                     aresetn = 1'b0;
    logic                     s_axis_tvalid = 1'b0;
    logic [RX_BUF_DATA_W-1:0] s_axis_tdata = '0;
    logic [RX_BUF_KEEP_W-1:0] s_axis_tkeep = '0;
    logic                     s_axis_tlast = 1'b0;
    logic [RX_BUF_USER_W-1:0] s_axis_tuser = '0;
    logic                     s_axis_tready;
    logic                     m_axis_tvalid;
    logic [RX_BUF_DATA_W-1:0] m_axis_tdata;
    logic [RX_BUF_KEEP_W-1:0] m_axis_tkeep;
    logic                     m_axis_tlast;
    logic [RX_BUF_USER_W-1:0] m_axis_tuser;
    logic                     m_axis_tready = 1'b0;
    rx_buf_status_t           buf_status;

    logic [RX_BUF_BEAT_W-1:0] m_beat;
    logic [RX_BUF_BEAT_W-1:0] s_beat;
    assign m_beat = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};

    always #5 aclk = ~aclk;

    rx_pkt_buffer #(.DEPTH(DEPTH)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .buf_status    (buf_status)
    );

    // Reference model: committed-but-unsent beats in order, the packet being
    // received, packet counters, and whether the rest of a packet is skipped.
    logic [RX_BUF_BEAT_W-1:0] exp_q[$];
    logic [RX_BUF_BEAT_W-1:0] part_q[$];
    int unsigned com_m = 0, drop_m = 0, sent_m = 0;
    bit dropping = 1'b0;
    bit rdy_m = 1'b0;
    bit rand_rdy = 1'b0;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        chk("pkt_committed", 640'(buf_status.pkt_committed), 640'(com_m));
        chk("pkt_dropped", 640'(buf_status.pkt_dropped), 640'(drop_m));
        chk("pkt_sent", 640'(buf_status.pkt_sent), 640'(sent_m));
        chk("occupancy", 640'(buf_status.occupancy), 640'(exp_q.size() + part_q.size()));
    endtask

    function automatic logic [RX_BUF_BEAT_W-1:0] rand_beat(input logic last);
        logic [RX_BUF_DATA_W-1:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return {16'($urandom), 32'($urandom), last, 32'($urandom), 32'($urandom), d};
    endfunction

    // One clock: model the edge from the current inputs/outputs, then advance.
    task automatic tick();
        logic [RX_BUF_BEAT_W-1:0] exp_b;
        int unsigned occ_pre;
        bit hs, acc;
        if (rand_rdy) m_axis_tready = ($urandom_range(0, 3) != 0);
        occ_pre = exp_q.size() + part_q.size();
        hs  = m_axis_tvalid && m_axis_tready;
        acc = s_axis_tvalid && rdy_m;
        chk("s_tready", 640'(s_axis_tready), 640'(rdy_m));
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 640'(m_axis_tvalid), 640'(0));
            end else begin
                exp_b = exp_q.pop_front();
                chk("m_beat", 640'(m_beat), 640'(exp_b));
                if (exp_b[RX_BUF_LAST_BIT]) sent_m++;
            end
        end
        if (acc) begin
            if (!dropping) begin
                if (occ_pre < DEPTH) begin
                    part_q.push_back(s_beat);
                    if (s_axis_tlast) begin
                        foreach (part_q[i]) exp_q.push_back(part_q[i]);
                        part_q.delete();
                        com_m++;
                    end
                end else begin
                    part_q.delete();
                    drop_m++;
                    dropping = !s_axis_tlast;
                end
            end else if (s_axis_tlast) begin
                dropping = 1'b0;
            end
        end
        @(posedge aclk);
        #1;
        rdy_m = 1'b1;
    endtask

    task automatic set_beat(input logic last);
        s_beat = rand_beat(last);
        {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata} = s_beat;
        s_axis_tvalid = 1'b1;
    endtask

    task automatic send_pkt(input int unsigned len, input bit gaps);
        for (int unsigned i = 0; i < len; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
                    s_axis_tvalid = 1'b0;
                    tick();
                end
            end
            set_beat(i == len - 1);
            tick();
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset(input int unsigned cycles);
        aresetn = 1'b0;
        repeat (cycles) begin
            @(posedge aclk);
            #1;
        end
        exp_q.delete();
        part_q.delete();
        com_m = 0; drop_m = 0; sent_m = 0;
        dropping = 1'b0;
        rdy_m = 1'b0;
        chk("rst_m_tvalid", 640'(m_axis_tvalid), 640'(0));
        chk("rst_s_tready", 640'(s_axis_tready), 640'(0));
        chk_status();
        aresetn = 1'b1;
    endtask

    task automatic drain();
        rand_rdy = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 400 && (exp_q.size() != 0 || m_axis_tvalid); i++) tick();
        chk("drain_left", 640'(exp_q.size()), 640'(0));
        chk("drain_tvalid", 640'(m_axis_tvalid), 640'(0));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        do_reset(3);
        tick();
        chk("tready_after_rst", 640'(s_axis_tready), 640'(1));

        // 1-beat packet: first beat shows two edges after the write edge
        m_axis_tready = 1'b1;
        set_beat(1'b1);
        tick();
        s_axis_tvalid = 1'b0;
        chk("lat_e0", 640'(m_axis_tvalid), 640'(0));
        tick();
        chk("lat_e1", 640'(m_axis_tvalid), 640'(0));
        tick();
        chk("lat_e2", 640'(m_axis_tvalid), 640'(1));
        chk("lat_beat", 640'(m_beat), 640'(exp_q[0]));
        tick();
        tick();
        chk_status();
        chk("t1_sent", 640'(buf_status.pkt_sent), 640'(1));

        // 3-beat packet held while QDMA stalls, then full-rate release
        m_axis_tready = 1'b0;
        send_pkt(3, 1'b0);
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_tvalid", 640'(m_axis_tvalid), 640'(1));
            chk("stall_beat", 640'(m_beat), 640'(exp_q[0]));
            tick();
        end
        chk("stall_occ", 640'(buf_status.occupancy), 640'(3));
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("burst_tvalid", 640'(m_axis_tvalid), 640'(1));
            chk("burst_tlast", 640'(m_axis_tlast), 640'(i == 2));
            tick();
        end
        chk("burst_done", 640'(m_axis_tvalid), 640'(0));
        chk_status();

        // 60 committed, 8-beat packet does not fit
        m_axis_tready = 1'b0;
        send_pkt(60, 1'b0);
        send_pkt(8, 1'b0);
        tick();
        chk("fit_occ", 640'(buf_status.occupancy), 640'(60));
        chk("fit_drop", 640'(buf_status.pkt_dropped), 640'(1));
        chk_status();
        drain();
        chk_status();

        // Oversize packet is dropped, next one passes
        m_axis_tready = 1'b1;
        send_pkt(70, 1'b0);
        tick();
        chk("big_occ", 640'(buf_status.occupancy), 640'(0));
        chk("big_drop", 640'(buf_status.pkt_dropped), 640'(2));
        chk("big_tvalid", 640'(m_axis_tvalid), 640'(0));
        send_pkt(2, 1'b0);
        drain();
        chk_status();

        // Exactly DEPTH beats fits
        m_axis_tready = 1'b0;
        send_pkt(DEPTH, 1'b0);
        tick();
        chk("exact_occ", 640'(buf_status.occupancy), 640'(DEPTH));
        chk_status();
        drain();
        chk_status();

        // Reset during beat 2 of a 5-beat packet with one packet buffered
        m_axis_tready = 1'b0;
        send_pkt(2, 1'b0);
        set_beat(1'b0);
        tick();
        set_beat(1'b0);
        tick();
        set_beat(1'b0);
        do_reset(1);
        s_axis_tvalid = 1'b0;
        tick();
        m_axis_tready = 1'b1;
        send_pkt(3, 1'b0);
        drain();
        chk_status();
        chk("post_rst_sent", 640'(buf_status.pkt_sent), 640'(1));

        // Randomized traffic with random QDMA stalls
        rand_rdy = 1'b1;
        for (int p = 0; p < 30; p++) begin
            send_pkt(($urandom_range(0, 9) == 0) ? 70 : $urandom_range(1, 24), 1'b1);
            chk_status();
        end
        drain();
        chk_status();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_pkt_buffer.md
Name: rx_pkt_buffer

Overview:
Store-and-forward packet buffer between the RX filter output and the QDMA C2H AXI-Stream input. It accepts filtered 512-bit beats without back-pressuring the filter. Only complete packets are released to QDMA. A packet that cannot fit is discarded whole, so QDMA never sees a truncated frame. Commit, drop and egress counts are exported for the status register block.

Parameters:
DEPTH, 64, buffer capacity in beats; must be a power of 2, minimum 4.
AW, $clog2(DEPTH), address width; derived, do not override.

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_axis_tvalid  in  1  beat valid from filter
s_axis_tdata  in  512  beat data
s_axis_tkeep  in  64  byte enables
s_axis_tlast  in  1  last beat of packet
s_axis_tuser  in  48  sideband, stored per beat
s_axis_tready  out  1  registered; 0 in reset, 1 from the first cycle after reset
m_axis_tvalid  out  1  beat valid to QDMA
m_axis_tdata  out  512  beat data
m_axis_tkeep  out  64  byte enables
m_axis_tlast  out  1  last beat
m_axis_tuser  out  48  sideband
m_axis_tready  in  1  QDMA ready
buf_status  out  rx_buf_status_t  {pkt_committed[31:0], pkt_dropped[31:0], pkt_sent[31:0], occupancy[AW:0]}

Behaviour:
- Reset (aresetn=0 at a posedge):
  - wr_ptr, wr_commit, rd_ptr cleared to 0; all counters cleared to 0.
  - FSM goes to ACCEPT; output register is emptied.
  - m_axis_tvalid=0 and s_axis_tready=0 for the reset cycle.
  - Reset mid-packet discards all buffered data; no partial output is ever produced.
- Pointers:
  - wr_ptr, wr_commit and rd_ptr are AW+1 bits with natural wrap.
  - free = DEPTH - (wr_ptr - rd_ptr), computed from registered values only.
  - A read in the same cycle does not grant write credit that cycle.
- Write FSM, state ACCEPT:
  - Beat accepted (s_axis_tvalid and s_axis_tready):
    - If free>0: write the beat at wr_ptr and increment wr_ptr.
      - If tlast: wr_commit <= wr_ptr+1, pkt_committed++.
    - If free==0: wr_ptr <= wr_commit (rewind), pkt_dropped++.
      - If tlast: stay in ACCEPT; otherwise go to DROP.
- Write FSM, state DROP:
  - Beats are discarded; on an accepted tlast beat, go to ACCEPT.
- Drop rules:
  - A packet longer than DEPTH beats is always dropped.
  - A packet is dropped if its tlast beat arrives with free==0.
  - A packet filling exactly the remaining space is committed.
- Read side:
  - Beats are readable while rd_ptr != wr_commit.
  - Uncommitted beats are never visible on m_axis.
  - rx_buf_ram has a 1-cycle registered read, followed by a 1-entry output register.
  - Latency: tlast written at cycle N -> wr_commit visible N+1 -> first beat of that packet on m_axis_tvalid at N+2 at the earliest, provided the output register is empty.
  - After that, full throughput: 1 beat/cycle while m_axis_tready=1.
- AXI-S rules on m_axis:
  - While m_axis_tvalid=1 and m_axis_tready=0, all m_axis signals are held stable.
  - tvalid never drops without a handshake.
- Counters and occupancy:
  - pkt_sent increments on an m_axis handshake with tlast.
  - Counters are 32-bit and wrap at 2^32 silently.
  - occupancy = wr_ptr - rd_ptr; it includes uncommitted beats.
- Simultaneous events:
  - A commit and a read in the same cycle are both honoured.
  - A rewind never moves wr_ptr behind rd_ptr, because wr_commit is always at or ahead of rd_ptr.

Decomposition:
- packet_pkg holds:
  - the rx_buf_status_t struct;
  - the RX_BUF_BEAT_W = 512+64+1+48 = 625 constant (beat word = {tuser, tlast, tkeep, tdata}).
- One sub-module, rx_buf_ram: simple dual-port, DEPTH x RX_BUF_BEAT_W, registered read, inferred as BRAM/URAM.
- The top level holds the FSM, pointers, counters and the output register.

Test Plan:
- Single 1-beat packet, m_axis_tready=1 -> appears at N+2 with identical tdata/tkeep/tuser; pkt_committed=1, pkt_sent=1.
- 3-beat packet, m_axis_tready=0 throughout -> m_axis_tvalid=1 with beat0 held stable indefinitely; occupancy=3; release tready -> 3 beats in 3 cycles, tlast on the third.
- DEPTH=64, tready=0: 60-beat packet committed, then 8-beat packet -> second packet dropped; pkt_dropped=1, occupancy=60; first packet is later sent intact.
- 70-beat packet into an empty buffer (DEPTH=64) -> nothing on m_axis; pkt_dropped=1, occupancy=0; the following 2-beat packet passes normally.
- Packet of exactly 64 beats into an empty buffer -> committed and sent; occupancy peaks at 64.
- aresetn pulsed during beat 2 of a 5-beat packet with 1 complete packet buffered -> m_axis_tvalid=0 next cycle; all counters 0; the next packet is sent correctly.
